// File: rtl/avm_pio_master.sv
// Avalon-MM PIO master: one command at a time, one bus cycle per access.
// Define AVM_PIO_MASTER_READBACK_EN to verify every write with a read-back.
module avm_pio_master #(
  parameter int READ_LATENCY = 1,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_mismatch,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT_RD,
    RESP
  } state_t;

  localparam logic [2:0] LAST = 3'(READ_LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic [1:0]        r_addr;
  logic [31:0]       r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_accept;
  logic              w_last;
  logic              w_unused;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_last   = (r_state == WAIT_RD) && (r_cnt == LAST);
  assign w_unused = ^avm_readdata;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = cmd_write ? WRITE : READ;
`ifdef AVM_PIO_MASTER_READBACK_EN
      WRITE:   w_next = READ;
`else
      WRITE:   w_next = RESP;
`endif
      READ:    w_next = WAIT_RD;
      WAIT_RD: if (w_last) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        if (cmd_write) r_rsp_data <= '0;
      end
      // cleared while in READ so it is zero on WAIT_RD entry
      if (r_state == READ) r_cnt <= '0;
      else if (r_state == WAIT_RD && r_cnt != LAST)
        r_cnt <= r_cnt + 3'd1;
      if (w_last) r_rsp_data <= avm_readdata[DATA_W-1:0];
    end
  end

`ifdef AVM_PIO_MASTER_READBACK_EN
  logic r_is_wr;
  logic r_mm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_wr <= 1'b0;
      r_mm    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_wr <= cmd_write;
        r_mm    <= 1'b0;
      end
      if (w_last)
        r_mm <= r_is_wr &&
          (avm_readdata[DATA_W-1:0] != r_wdata[DATA_W-1:0]);
    end
  end

  assign rsp_mismatch = r_mm;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign cmd_ready      = reset_n && (r_state == IDLE);
  assign rsp_valid      = (r_state == RESP);
  assign rsp_data       = r_rsp_data;
  assign avm_chipselect = (r_state == WRITE) || (r_state == READ);
  assign avm_write_n    = (r_state != WRITE);
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_avm_pio_master.sv
// Scoreboard bench for avm_pio_master with PIO slave models.
// Main instance uses READ_LATENCY=1; a second uses READ_LATENCY=4.
module tb_avm_pio_master;

  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          mm;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_write, cmd_ready;
  logic [1:0]    cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_mismatch;
  logic [DW-1:0] rsp_data;
  logic [1:0]    avm_address;
  logic          avm_chipselect, avm_write_n;
  logic [31:0]   avm_writedata, avm_readdata;

  logic          b_cmd_valid, b_cmd_ready, b_rsp_valid, b_mm;
  logic [DW-1:0] b_rsp_data;
  logic [1:0]    b_addr;
  logic          b_cs, b_wn;
  logic [31:0]   b_wd, b_rdata;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_wr  = 0;
  int n_rd  = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int acc_cyc = 0;
  logic [31:0] last_wd;
  logic [1:0]  last_wa, last_ra;
  exp_t        sb[$];
  logic [31:0] shadow [4];
  logic        stuck = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avm_pio_master #(.READ_LATENCY(1), .DATA_W(DW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_mismatch(rsp_mismatch),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata)
  );

  avm_pio_master #(.READ_LATENCY(4), .DATA_W(DW)) u_d4 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(1'b0), .cmd_addr(2'd3),
    .cmd_wdata(32'd0),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
    .rsp_data(b_rsp_data), .rsp_mismatch(b_mm),
    .avm_address(b_addr),
    .avm_chipselect(b_cs),
    .avm_write_n(b_wn),
    .avm_writedata(b_wd),
    .avm_readdata(b_rdata)
  );

  // PIO slave for the main instance: data valid one cycle after a read
  logic [31:0] mem [4];
  logic [3:0]  vld  = '0;
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (avm_chipselect && !avm_write_n)
      mem[avm_address] <= avm_writedata;
    vld <= {vld[2:0], avm_chipselect && avm_write_n};
    if (avm_chipselect && avm_write_n)
      rd_q <= mem[avm_address] | {31'd0, stuck};
  end
  assign avm_readdata = vld[0] ? rd_q : 32'hDEAD_BE00;

  // latency-4 slave: 0x81 only on the 4th cycle after the read
  logic [3:0] b_vld = '0;
  always @(posedge clk) b_vld <= {b_vld[2:0], b_cs && b_wn};
  assign b_rdata = b_vld[3] ? 32'h81 : {24'h0, 4'h1, b_vld};

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t expect_of(input logic w, input logic [1:0] a,
                                     input logic [31:0] d);
    exp_t e;
    logic [31:0] v;
    if (w) begin
`ifdef AVM_PIO_MASTER_READBACK_EN
      v = d | {31'd0, stuck};
      e.data = v[DW-1:0];
      e.mm   = (v[DW-1:0] != d[DW-1:0]);
      e.lat  = 4;
`else
      v = d;
      e.data = '0;
      e.mm   = 1'b0;
      e.lat  = 2;
`endif
    end else begin
      v = shadow[a] | {31'd0, stuck};
      e.data = v[DW-1:0];
      e.mm   = 1'b0;
      e.lat  = 3;
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    bit seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) seen = 0;
      else begin
        if (avm_chipselect && !avm_write_n) begin
          n_wr++;
          last_wd = avm_writedata;
          last_wa = avm_address;
        end
        if (avm_chipselect && avm_write_n) begin
          n_rd++;
          last_ra = avm_address;
        end
        if (cmd_valid && cmd_ready) begin
          n_acc++;
          acc_cyc = cyc;
        end
        if (rsp_valid && !seen) begin
          seen = 1;
          chk("rsp_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0)
            chk("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
        end
        if (rsp_valid && rsp_ready) begin
          seen = 0;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_mm", 32'(rsp_mismatch), 32'(e.mm));
          end
          n_rsp++;
        end
      end
    end
  end

  task automatic wait_accept(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready && cmd_valid) ok = 1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic issue(input logic w, input logic [1:0] a,
                       input logic [31:0] d);
    int n0;
    bit ok;
    sb.push_back(expect_of(w, a, d));
    if (w) shadow[a] = d;
    n0 = n_rsp;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    wait_accept("accept");
    @(posedge clk); #1;
    cmd_valid = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (n_rsp != n0) ok = 1;
    end
    chk("rsp_done", 32'(ok), 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_mm"}, 32'(rsp_mismatch), 0);
    chk({tag, "_cs"}, 32'(avm_chipselect), 0);
    chk({tag, "_wn"}, 32'(avm_write_n), 1);
    chk({tag, "_addr"}, 32'(avm_address), 0);
    chk({tag, "_wd"}, avm_writedata, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin : main
    int w0, r0, a0, n0, t0, nv;
    bit ok;
    exp_t e1;
    reset_n = 0; rsp_ready = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    b_cmd_valid = 0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    #22;
    chk_reset_outs("rst");
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(cmd_ready), 1);

    // write 0xA5 to addr 0
    w0 = n_wr; r0 = n_rd;
    issue(1, 2'd0, 32'h0000_00A5);
    chk("wr_cycles", 32'(n_wr - w0), 1);
    chk("wr_data", last_wd, 32'hA5);
    chk("wr_addr", 32'(last_wa), 0);
`ifdef AVM_PIO_MASTER_READBACK_EN
    chk("wr_rb_reads", 32'(n_rd - r0), 1);
`else
    chk("wr_no_reads", 32'(n_rd - r0), 0);
`endif
    chk("idle_cs", 32'(avm_chipselect), 0);
    chk("idle_wn", 32'(avm_write_n), 1);
    chk("hold_wd", avm_writedata, 32'hA5);

    // slave holding 0x3C, plus a few other patterns
    issue(1, 2'd1, 32'h0000_003C);
    r0 = n_rd;
    issue(0, 2'd1, 32'h0);
    chk("rd_cycles", 32'(n_rd - r0), 1);
    chk("rd_addr", 32'(last_ra), 1);
    issue(1, 2'd2, 32'hFFFF_FFC3);
    issue(1, 2'd3, 32'h0000_0100);
    issue(0, 2'd2, 32'h0);
    issue(0, 2'd3, 32'h0);
    issue(0, 2'd0, 32'h0);

    // bit 0 stuck at 1 in the slave
    stuck = 1;
    issue(1, 2'd0, 32'h0000_005A);
    issue(0, 2'd0, 32'h0);
    stuck = 0;
    issue(1, 2'd0, 32'h0000_005A);

    // backpressure with a second command held on the port
    e1 = expect_of(0, 2'd1, 32'h0);
    sb.push_back(e1);
    sb.push_back(expect_of(1, 2'd2, 32'h77));
    shadow[2] = 32'h77;
    a0 = n_acc; n0 = n_rsp;
    @(posedge clk); #1;
    rsp_ready = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 2'd1;
    wait_accept("bp_accept1");
    @(posedge clk); #1;
    cmd_write = 1; cmd_addr = 2'd2; cmd_wdata = 32'h77;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    chk("bp_rsp_seen", 32'(ok), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 32'(e1.data));
      chk("bp_cmd_ready", 32'(cmd_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (n_acc - a0 == 2) ok = 1;
    end
    @(posedge clk); #1 cmd_valid = 0;
    chk("bp_accept2", 32'(ok), 1);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (n_rsp - n0 == 2) ok = 1;
    end
    chk("bp_rsp2", 32'(ok), 1);
    repeat (3) @(negedge clk);
    chk("bp_accepts", 32'(n_acc - a0), 2);

    // abort a read in WAIT_RD with reset
    issue(0, 2'd1, 32'h0);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 2'd2;
    wait_accept("ab_accept");
    @(posedge clk); #1 cmd_valid = 0;
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    chk_reset_outs("abort");
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    chk("ab_rdy", 32'(cmd_ready), 1);
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    chk("ab_no_rsp", 32'(nv), 0);
    issue(0, 2'd2, 32'h0);

    // latency-4 instance must not return stale data
    @(posedge clk); #1 b_cmd_valid = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (b_cmd_ready) ok = 1;
    end
    chk("l4_accept", 32'(ok), 1);
    t0 = cyc;
    @(posedge clk); #1 b_cmd_valid = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (b_rsp_valid) ok = 1;
    end
    chk("l4_rsp_seen", 32'(ok), 1);
    chk("l4_latency", 32'(cyc - t0), 6);
    chk("l4_data", 32'(b_rsp_data), 32'h81);
    chk("l4_mm", 32'(b_mm), 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
